regfile_write_scheduler: RTL and testbench
==========================================

REGFILE_WRITE_SCHEDULER -- requirements
Module: regfile_write_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of write requesters.
REQ-002 SHALL have parameter AW, default 5, register address width (32 registers).
REQ-003 SHALL have parameter DW, default 64, register data width.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester write request.
REQ-007 SHALL have port req_addr  input  NREQ*AW  per-requester target register, requester i at bits [i*AW +: AW].
REQ-008 SHALL have port req_data  input  NREQ*DW  per-requester write data, requester i at bits [i*DW +: DW].
REQ-009 SHALL have port req_ready  output  NREQ  one-cycle accept pulse per requester.
REQ-010 SHALL have ports write_addr_1, write_addr_2  output  AW  register-file write addresses.
REQ-011 SHALL have ports write_data_1, write_data_2  output  DW  register-file write data.
REQ-012 SHALL have ports write_enable_1, write_enable_2  output  1  register-file write strobes (file writes on strobe rising edge).
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port writes_issued  output  16  count of strobes issued, wraps 0xFFFF->0.

Function
REQ-015 SHALL implement states IDLE, SETUP, STROBE, HOLD; IDLE->SETUP when any grant issued, SETUP->STROBE->HOLD->IDLE unconditionally.
REQ-016 SHALL, in IDLE, scan requesters starting at rr_ptr circularly; first valid requester gets port 1, next valid requester with address different from port-1 address gets port 2.
REQ-017 SHALL skip (not grant) a requester whose address equals the port-1 address; it remains pending for the next batch.
REQ-018 SHALL assert req_ready combinationally in IDLE only for granted requesters; transfer occurs on req_valid && req_ready; requesters hold addr/data/valid until accepted.
REQ-019 SHALL register granted addr/data into write_addr_x/write_data_x on the IDLE->SETUP edge; unused port keeps previous addr/data and its enable stays 0.
REQ-020 SHALL hold write_enable_x low in SETUP, high in STROBE only for used ports, low in HOLD; addr/data stable from SETUP through HOLD (setup and hold margin for edge-triggered file).
REQ-021 SHALL update rr_ptr on grant to (index of last granted requester + 1) mod NREQ.
REQ-022 SHALL never assert req_ready outside IDLE; batch latency request-to-strobe = 2 cycles, batch period 4 cycles, max 2 writes per batch.
REQ-023 SHALL add number of strobed ports (1 or 2) to writes_issued on STROBE entry.
REQ-024 SHALL remain in IDLE with all req_ready low when no req_valid is high.

Reset
REQ-025 SHALL on rst asynchronously force state IDLE, rr_ptr 0, write_enable_x 0, write_addr_x 0, write_data_x 0, writes_issued 0, busy 0, req_ready 0 (req_ready gated by !rst).
REQ-026 SHALL, if rst asserts in SETUP, issue no strobe for that batch; if in STROBE, drop enables immediately (file write already triggered stands); accepted requests are not replayed.

Structure
REQ-027 SHALL take AW, DW, NREQ defaults and state enumeration from shared package regfile_pkg.
REQ-028 SHALL place circular first/second-pick logic in sub-module rr_pick (inputs valid, addresses, rr_ptr; outputs two one-hot grants).

Verification
REQ-029 SHALL check single request: req0 addr 3 data 0xA5 -> req_ready[0] in IDLE, write_enable_1 high 2 cycles later with addr 3 data 0xA5, write_enable_2 stays 0.
REQ-030 SHALL check dual: req1 addr 4, req2 addr 9, rr_ptr 0 -> port1 = req1, port2 = req2, both strobed same cycle, writes_issued +2, rr_ptr 3.
REQ-031 SHALL check conflict: req0 and req1 both addr 7 -> only req0 granted; req1 granted next batch 4 cycles later.
REQ-032 SHALL check fairness: all 4 valid continuously for 4 batches -> each requester granted exactly twice, order 0,1 / 2,3 / 0,1 / 2,3.
REQ-033 SHALL check reset in SETUP: rst pulse -> no strobe, all outputs 0, busy 0, rr_ptr 0.
REQ-034 SHALL check counter wrap: writes_issued preset via 65535 strobes -> next strobe reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared parameters, state encoding and helpers for the register-file write scheduler.
package regfile_pkg;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // A single requester still needs a one-bit pointer so the port stays legal.
  function automatic int ptrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_scheduler_rr_pick.sv
// Circular two-way picker: first valid requester from rrPtr_i, then the next
// valid one whose address differs from the first pick.
module rr_pick
  import regfile_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int PW   = ptrWidth(NREQ_DEF)
) (
  input  logic [NREQ-1:0]    valid_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [PW-1:0]      rrPtr_i,
  output logic [NREQ-1:0]    grant1_o,
  output logic [NREQ-1:0]    grant2_o
);

  logic [AW-1:0] addrArr [NREQ];
  logic [AW-1:0] firstAddr;
  logic          haveFirst;
  logic          haveSecond;

  for (genvar g = 0; g < NREQ; g++) begin : gUnpack
    assign addrArr[g] = addr_i[g*AW +: AW];
  end

  // Outer loop walks scan order; the inner loop keeps every select constant.
  always_comb begin
    grant1_o   = '0;
    grant2_o   = '0;
    haveFirst  = 1'b0;
    haveSecond = 1'b0;
    firstAddr  = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if ((j == ((int'(rrPtr_i) + k) % NREQ)) && valid_i[j]) begin
          if (!haveFirst) begin
            grant1_o[j] = 1'b1;
            haveFirst   = 1'b1;
            firstAddr   = addrArr[j];
          end else if (!haveSecond && (addrArr[j] != firstAddr)) begin
            grant2_o[j] = 1'b1;
            haveSecond  = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Merges up to two requester writes per batch onto a dual-port register file,
// framing each write with a setup cycle and a hold cycle around the strobe.
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [AW-1:0]      write_addr_1,
  output logic [AW-1:0]      write_addr_2,
  output logic [DW-1:0]      write_data_1,
  output logic [DW-1:0]      write_data_2,
  output logic               write_enable_1,
  output logic               write_enable_2,
  output logic               busy,
  output logic [15:0]        writes_issued
);

  localparam int PW = ptrWidth(NREQ);

  state_e          state_q, state_d;
  logic [PW-1:0]   rrPtr_q, rrPtr_d;
  logic [NREQ-1:0] grant1, grant2;
  logic            grantAny;
  logic            grantTwo;
  logic [PW-1:0]   lastIdx;
  logic [AW-1:0]   gAddr1, gAddr2;
  logic [DW-1:0]   gData1, gData2;
  logic [AW-1:0]   addr1_q, addr2_q;
  logic [DW-1:0]   data1_q, data2_q;
  logic            used2_q;
  logic            we1_q, we2_q;
  logic [15:0]     writes_q, writes_d;

  rr_pick #(
    .NREQ (NREQ),
    .AW   (AW),
    .PW   (PW)
  ) uPick (
    .valid_i  (req_valid),
    .addr_i   (req_addr),
    .rrPtr_i  (rrPtr_q),
    .grant1_o (grant1),
    .grant2_o (grant2)
  );

  assign grantAny = |grant1;
  assign grantTwo = |grant2;

  always_comb begin
    gAddr1  = '0;
    gAddr2  = '0;
    gData1  = '0;
    gData2  = '0;
    lastIdx = '0;
    for (int j = 0; j < NREQ; j++) begin
      gAddr1 |= {AW{grant1[j]}} & req_addr[j*AW +: AW];
      gAddr2 |= {AW{grant2[j]}} & req_addr[j*AW +: AW];
      gData1 |= {DW{grant1[j]}} & req_data[j*DW +: DW];
      gData2 |= {DW{grant2[j]}} & req_data[j*DW +: DW];
      if (grant2[j] || (grant1[j] && !grantTwo)) begin
        lastIdx = PW'(j);
      end
    end
  end

  // The pointer moves past whichever requester was granted last in scan order.
  always_comb begin
    rrPtr_d = rrPtr_q;
    if ((state_q == IDLE) && grantAny) begin
      rrPtr_d = (lastIdx == PW'(NREQ - 1)) ? '0 : lastIdx + 1'b1;
    end
  end

  assign writes_d = (state_q == SETUP) ? writes_q + {14'd0, used2_q, ~used2_q} : writes_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grantAny) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if ((state_q == IDLE) && !rst) begin
      req_ready = (grant1 | grant2) & req_valid;
    end
    busy = (state_q != IDLE);
  end

  // An unused port 2 keeps its old address/data so the file inputs do not toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr_q  <= '0;
      addr1_q  <= '0;
      addr2_q  <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
      used2_q  <= 1'b0;
      we1_q    <= 1'b0;
      we2_q    <= 1'b0;
      writes_q <= '0;
    end else begin
      rrPtr_q  <= rrPtr_d;
      writes_q <= writes_d;
      we1_q    <= (state_q == SETUP);
      we2_q    <= (state_q == SETUP) && used2_q;
      if ((state_q == IDLE) && grantAny) begin
        addr1_q <= gAddr1;
        data1_q <= gData1;
        used2_q <= grantTwo;
        if (grantTwo) begin
          addr2_q <= gAddr2;
          data2_q <= gData2;
        end
      end
    end
  end

  assign write_addr_1   = addr1_q;
  assign write_addr_2   = addr2_q;
  assign write_data_1   = data1_q;
  assign write_data_2   = data2_q;
  assign write_enable_1 = we1_q;
  assign write_enable_2 = we2_q;
  assign writes_issued  = writes_q;

  a_grantOnehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(grant1) && $onehot0(grant2) && ((grant1 & grant2) == '0));
  a_readyIdleOnly: assert property (@(posedge clk) disable iff (rst)
    (state_q != IDLE) |-> (req_ready == '0));

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Randomised and directed bench for regfile_write_scheduler with a batch-level
// reference model feeding a scoreboard that a strobe monitor drains.
module tb_regfile_write_scheduler;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 64;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [AW-1:0]      write_addr_1, write_addr_2;
  logic [DW-1:0]      write_data_1, write_data_2;
  logic               write_enable_1, write_enable_2;
  logic               busy;
  logic [15:0]        writes_issued;

  regfile_write_scheduler #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .write_addr_1   (write_addr_1),
    .write_addr_2   (write_addr_2),
    .write_data_1   (write_data_1),
    .write_data_2   (write_data_2),
    .write_enable_1 (write_enable_1),
    .write_enable_2 (write_enable_2),
    .busy           (busy),
    .writes_issued  (writes_issued)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } txn_t;

  typedef struct {
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    bit            has2;
    logic [AW-1:0] a2;
    logic [DW-1:0] d2;
    logic [15:0]   cnt;
    int            due;
  } exp_t;

  txn_t rq [NREQ][$];
  exp_t sb [$];

  int            cycleCount = 0;
  int            nChecks = 0;
  int            nFail = 0;
  int            mPhase = 0;
  int            mRr = 0;
  logic [15:0]   mCnt = '0;
  logic [AW-1:0] mA1 = '0, mA2 = '0;
  logic [DW-1:0] mD1 = '0, mD2 = '0;
  logic [NREQ-1:0] accepted = '0;
  bit            randomOn = 1'b0;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCount);
    end
  endtask

  task automatic addTxn(input int i, input int a, input logic [DW-1:0] d);
    txn_t t;
    t.a = AW'(a);
    t.d = d;
    rq[i].push_back(t);
  endtask

  // Requesters pop only what was accepted and otherwise hold valid/addr/data steady.
  task automatic applyStimulus();
    for (int i = 0; i < NREQ; i++) begin
      if (accepted[i] && (rq[i].size() > 0)) rq[i].delete(0);
    end
    accepted = '0;
    if (randomOn) begin
      for (int i = 0; i < NREQ; i++) begin
        if ((rq[i].size() == 0) && ($urandom_range(0, 2) == 0)) begin
          addTxn(i, int'($urandom_range(0, 7)), {$urandom, $urandom});
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]          = 1'b1;
        req_addr[i*AW +: AW]  = rq[i][0].a;
        req_data[i*DW +: DW]  = rq[i][0].d;
      end else begin
        req_valid[i]          = 1'b0;
        req_addr[i*AW +: AW]  = '0;
        req_data[i*DW +: DW]  = '0;
      end
    end
  endtask

  // Batch-level model: an idle slot grants up to two distinct-address writers,
  // then three busy cycles pass before the next slot.
  task automatic modelStep();
    logic [NREQ-1:0] expReady;
    int p1, p2, j, last;
    exp_t e;
    expReady = '0;
    p1 = -1;
    p2 = -1;
    checkOutput("busy", 64'(busy), 64'(mPhase != 0));
    checkOutput("write_addr_1", 64'(write_addr_1), 64'(mA1));
    checkOutput("write_data_1", write_data_1, mD1);
    checkOutput("write_addr_2", 64'(write_addr_2), 64'(mA2));
    checkOutput("write_data_2", write_data_2, mD2);
    if (mPhase == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (mRr + k) % NREQ;
        if (req_valid[j]) begin
          if (p1 < 0) p1 = j;
          else if ((p2 < 0) && (req_addr[j*AW +: AW] != req_addr[p1*AW +: AW])) p2 = j;
        end
      end
      if (p1 >= 0) expReady[p1] = 1'b1;
      if (p2 >= 0) expReady[p2] = 1'b1;
      checkOutput("req_ready_idle", 64'(req_ready), 64'(expReady));
      if (p1 >= 0) begin
        mA1 = req_addr[p1*AW +: AW];
        mD1 = req_data[p1*DW +: DW];
        e.has2 = (p2 >= 0);
        if (e.has2) begin
          mA2 = req_addr[p2*AW +: AW];
          mD2 = req_data[p2*DW +: DW];
        end
        mCnt  = mCnt + (e.has2 ? 16'd2 : 16'd1);
        e.a1  = mA1;
        e.d1  = mD1;
        e.a2  = mA2;
        e.d2  = mD2;
        e.cnt = mCnt;
        e.due = cycleCount + 2;
        sb.push_back(e);
        last   = e.has2 ? p2 : p1;
        mRr    = (last + 1) % NREQ;
        mPhase = 1;
      end
    end else begin
      checkOutput("req_ready_busy", 64'(req_ready), 64'd0);
      mPhase = (mPhase + 1) % 4;
    end
    accepted = req_ready & req_valid;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if ((sb.size() > 0) && (sb[0].due < cycleCount)) begin
        nChecks++;
        nFail++;
        $display("[TB] FAIL missing_strobe: no strobe observed, expected at cycle %0d (now %0d)", sb[0].due, cycleCount);
        sb.delete(0);
      end
      if (write_enable_1 || write_enable_2) begin
        if (sb.size() == 0) begin
          nChecks++;
          nFail++;
          $display("[TB] FAIL unexpected_strobe: we1=%0b we2=%0b, expected none (cycle %0d)",
                   write_enable_1, write_enable_2, cycleCount);
        end else begin
          e = sb.pop_front();
          checkOutput("strobe_cycle", 64'(cycleCount), 64'(e.due));
          checkOutput("strobe_we1", 64'(write_enable_1), 64'd1);
          checkOutput("strobe_we2", 64'(write_enable_2), 64'(e.has2));
          checkOutput("strobe_addr1", 64'(write_addr_1), 64'(e.a1));
          checkOutput("strobe_data1", write_data_1, e.d1);
          if (e.has2) begin
            checkOutput("strobe_addr2", 64'(write_addr_2), 64'(e.a2));
            checkOutput("strobe_data2", write_data_2, e.d2);
          end
          checkOutput("writes_issued", 64'(writes_issued), 64'(e.cnt));
        end
      end
    end
  end

  task automatic cycle();
    @(negedge clk);
    if (!rst) modelStep();
    @(posedge clk);
    #1;
    applyStimulus();
  endtask

  // Asserted mid-cycle so the checks observe the asynchronous clear before any edge.
  task automatic doReset();
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_we1", 64'(write_enable_1), 64'd0);
    checkOutput("rst_we2", 64'(write_enable_2), 64'd0);
    checkOutput("rst_addr1", 64'(write_addr_1), 64'd0);
    checkOutput("rst_addr2", 64'(write_addr_2), 64'd0);
    checkOutput("rst_data1", write_data_1, 64'd0);
    checkOutput("rst_data2", write_data_2, 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_writes", 64'(writes_issued), 64'd0);
    sb.delete();
    mPhase   = 0;
    mRr      = 0;
    mCnt     = '0;
    mA1      = '0;
    mA2      = '0;
    mD1      = '0;
    mD2      = '0;
    accepted = '0;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((n < 200) && !((req_valid == '0) && (mPhase == 0) && (sb.size() == 0))) begin
      cycle();
      n++;
    end
    nChecks++;
    if (n >= 200) begin
      nFail++;
      $display("[TB] FAIL drain_timeout: still busy after %0d cycles, expected idle", n);
    end
  endtask

  // Seeds the strobe counter near its wrap point instead of issuing 65534 writes.
  task automatic presetCount(input logic [15:0] v);
    force dut.writes_d = v;
    @(posedge clk);
    #1;
    release dut.writes_d;
    mCnt = v;
    applyStimulus();
  endtask

  initial begin
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    @(posedge clk);
    #1;
    applyStimulus();
    doReset();

    addTxn(0, 3, 64'hA5);
    drain();

    doReset();
    addTxn(1, 4, 64'h1111_0000_0000_0004);
    addTxn(2, 9, 64'h2222_0000_0000_0009);
    drain();
    addTxn(0, 1, 64'h3333_0000_0000_0001);
    addTxn(3, 2, 64'h4444_0000_0000_0002);
    drain();

    doReset();
    addTxn(0, 7, 64'h0000_0000_0000_0700);
    addTxn(1, 7, 64'h0000_0000_0000_0701);
    drain();

    doReset();
    for (int i = 0; i < NREQ; i++) begin
      addTxn(i, 10 + i, 64'hF000 + 64'(i));
      addTxn(i, 20 + i, 64'hE000 + 64'(i));
    end
    drain();

    doReset();
    addTxn(2, 5, 64'hDEAD_BEEF_0000_0005);
    for (int n = 0; (n < 10) && (mPhase != 1); n++) cycle();
    doReset();
    repeat (8) cycle();
    addTxn(1, 6, 64'h0000_0000_0000_0606);
    drain();

    doReset();
    presetCount(16'hFFFE);
    addTxn(0, 1, 64'h0000_0000_0000_FFFF);
    drain();
    addTxn(0, 2, 64'h0000_0000_0001_0000);
    drain();

    randomOn = 1'b1;
    repeat (400) cycle();
    randomOn = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
